// File: rtl/mem_req_bridge_pkg.sv
// Shared decode constants for the memory-stage path.
// Contents:
//   state_e   - bridge FSM states
//   SZ_*      - access size encodings, shared with the controller
//   bus_size  - maps the reserved size code to a word access
package mem_req_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic [1:0] bus_size(input logic [1:0] sz);
    return (sz == 2'd3) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/mem_req_bridge.sv
// Memory-stage request bridge: turns one pipeline memory access into exactly
// one req/addr_ok/data_ok bus transaction, stalls the pipeline while it is
// outstanding and returns load data.
//
// state | meaning
// IDLE  | no transaction; launches one when memen_m & ~flush_m
// REQ   | req high, payload held until addr_ok
// WAIT  | address accepted, waiting for data_ok
// DONE  | access complete, stall released; held here while hold_m
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   memen_m, memwrite_m, size_m,
//   addr_m, wdata_m               memory-stage access request
//   flush_m, hold_m               memory-stage flush / external hold
//   stall_o, rdata_o              pipeline stall, load data (valid in DONE)
//   req, wr, size, addr, wdata    bus request channel
//   addr_ok, data_ok, rdata       bus handshake and read data
module mem_req_bridge
  import mem_req_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memen_m,
  input  logic              memwrite_m,
  input  logic [1:0]        size_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [DATA_W-1:0] wdata_m,
  input  logic              flush_m,
  input  logic              hold_m,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata
);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cancel_q, cancel_d;
  logic              launch;

  assign launch = (state_q == IDLE) && memen_m && !flush_m;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A cancelled transaction still completes on the bus, but returns to IDLE
  // instead of DONE so the flushed instruction never sees its result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (launch) state_d = REQ;
      REQ:  if (addr_ok) state_d = WAIT;
      WAIT: if (data_ok) state_d = cancel_q ? IDLE : DONE;
      DONE: if (!hold_m) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req     = (state_q == REQ);
    stall_o = launch || (state_q == REQ) || (state_q == WAIT);
  end

  always_comb begin
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cancel_d = cancel_q;
    rdata_d  = rdata_q;
    if (launch) begin
      wr_d     = memwrite_m;
      size_d   = bus_size(size_m);
      addr_d   = addr_m;
      wdata_d  = wdata_m;
      cancel_d = 1'b0;
    end else if (((state_q == REQ) || (state_q == WAIT)) && flush_m) begin
      cancel_d = 1'b1;
    end
    if ((state_q == WAIT) && data_ok && !cancel_q && !wr_q) begin
      rdata_d = rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cancel_q <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cancel_q <= cancel_d;
    end
  end

  assign wr      = wr_q;
  assign size    = size_q;
  assign addr    = addr_q;
  assign wdata   = wdata_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_req_bridge.sv
module tb_mem_req_bridge;
  import mem_req_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memen_m = 1'b0;
  logic        memwrite_m = 1'b0;
  logic [1:0]  size_m = 2'd0;
  logic [31:0] addr_m = '0;
  logic [31:0] wdata_m = '0;
  logic        flush_m = 1'b0;
  logic        hold_m = 1'b0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = '0;

  mem_req_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .memen_m(memen_m), .memwrite_m(memwrite_m), .size_m(size_m),
    .addr_m(addr_m), .wdata_m(wdata_m), .flush_m(flush_m), .hold_m(hold_m),
    .stall_o(stall_o), .rdata_o(rdata_o),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  bus_req_t    exp_req_q[$];
  logic [31:0] exp_rd_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_rdata = '0;

  // bus responder knobs
  int          ao_delay = 0;
  int          do_delay = 0;
  logic [31:0] bus_rdata = '0;
  logic        stray = 1'b0;

  function automatic bus_req_t mk_req(input logic w, input logic [1:0] s,
                                      input logic [31:0] a, input logic [31:0] d);
    bus_req_t r;
    r.wr = w; r.size = s; r.addr = a; r.wdata = d;
    return r;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus slave: addr_ok after ao_delay idle REQ cycles, data_ok do_delay cycles
  // after the cycle following addr_ok.
  int ao_cnt = 0, do_cnt = 0;
  bit pend = 0;
  always @(negedge clk) begin
    addr_ok = 1'b0;
    data_ok = 1'b0;
    if (!rst) begin
      ao_cnt = 0; do_cnt = 0; pend = 0;
    end else if (stray) begin
      addr_ok = 1'b1;
      data_ok = 1'b1;
      rdata   = 32'h7777_7777;
    end else if (pend) begin
      if (do_cnt == do_delay) begin
        data_ok = 1'b1; rdata = bus_rdata; pend = 0; do_cnt = 0;
      end else do_cnt++;
    end else if (req) begin
      if (ao_cnt == ao_delay) begin
        addr_ok = 1'b1; pend = 1; ao_cnt = 0;
      end else ao_cnt++;
    end
  end

  // Monitor / scoreboard
  logic     prev_req = 0, prev_ao = 0, prev_done = 0;
  bus_req_t prev_f;
  always @(negedge clk) begin
    bus_req_t cur;
    bus_req_t e;
    logic [31:0] er;
    logic done_now;
    #1;
    cur = mk_req(wr, size, addr, wdata);
    done_now = 1'b0;
    if (rst) begin
      if (prev_req && !prev_ao) begin
        check("req_held", req, 1'b1);
        if (req) check("req_fields_stable", cur, prev_f);
      end
      if (req && addr_ok) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %0h, required no transaction", addr);
        end else begin
          e = exp_req_q.pop_front();
          check("req_fields", cur, e);
        end
      end
      done_now = memen_m && !flush_m && !stall_o;
      if (done_now && !prev_done) begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got rdata_o %0h, required no completion", rdata_o);
        end else begin
          er = exp_rd_q.pop_front();
          check("rdata_o_done", rdata_o, er);
        end
      end
    end
    prev_req  = req && rst;
    prev_ao   = addr_ok;
    prev_f    = cur;
    prev_done = done_now;
  end

  task automatic access(input string name, input logic w, input logic [1:0] sz,
                        input logic [1:0] exp_sz, input logic [31:0] a,
                        input logic [31:0] wd, input int aod, input int dod,
                        input logic [31:0] rd, input int hold_cycles);
    int cnt;
    bit done;
    ao_delay = aod; do_delay = dod; bus_rdata = rd;
    exp_req_q.push_back(mk_req(w, exp_sz, a, wd));
    if (!w) model_rdata = rd;
    exp_rd_q.push_back(model_rdata);
    @(negedge clk);
    memen_m = 1'b1; memwrite_m = w; size_m = sz; addr_m = a; wdata_m = wd;
    flush_m = 1'b0; hold_m = 1'b0;
    cnt = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      #2;
      if (!stall_o) done = 1;
      else begin
        cnt++;
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: stall_o still high after 40 cycles, required release", name);
    end
    check({name, "_stall_cycles"}, cnt, 3 + aod + dod);
    for (int h = 0; h < hold_cycles; h++) begin
      hold_m = 1'b1;
      @(negedge clk);
      #2;
      check({name, "_held_stall"}, stall_o, 1'b0);
      check({name, "_held_req"}, req, 1'b0);
    end
    hold_m = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #2;
    check("rst_req", req, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_rdata_o", rdata_o, 32'h0);
    check("rst_bus_fields", {wr, size, addr, wdata}, 67'h0);
    memen_m = 1'b1;
    #1;
    check("rst_stall_comb", stall_o, 1'b1);
    memen_m = 1'b0;
    @(negedge clk); #2 rst = 1'b1;

    // best-case word load
    access("ld_word", 1'b0, SZ_WORD, SZ_WORD, 32'h0000_1000, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
    check("ld_word_rdata_o", rdata_o, 32'hDEAD_BEEF);

    // byte store, addr_ok delayed 3 cycles; store must not touch rdata_o
    access("st_byte", 1'b1, SZ_BYTE, SZ_BYTE, 32'h0000_2003, 32'h1100_0000, 3, 0, 32'h5555_5555, 0);
    check("st_byte_rdata_o", rdata_o, 32'hDEAD_BEEF);

    // flush in IDLE suppresses the access
    @(negedge clk);
    memen_m = 1'b1; memwrite_m = 1'b0; size_m = SZ_WORD; addr_m = 32'h0000_7000; flush_m = 1'b1;
    #2 check("idle_flush_stall", stall_o, 1'b0);
    @(negedge clk); #2;
    check("idle_flush_req", req, 1'b0);
    check("idle_flush_stall2", stall_o, 1'b0);
    @(negedge clk);
    flush_m = 1'b0; memen_m = 1'b0;
    #2 check("idle_flush_req2", req, 1'b0);

    // flush during WAIT: transaction completes, result discarded
    ao_delay = 0; do_delay = 2; bus_rdata = 32'h1234_5678;
    exp_req_q.push_back(mk_req(1'b0, SZ_WORD, 32'h0000_3000, 32'h0));
    @(negedge clk);
    memen_m = 1'b1; memwrite_m = 1'b0; size_m = SZ_WORD; addr_m = 32'h0000_3000; wdata_m = 32'h0;
    #2 check("wflush_stall_idle", stall_o, 1'b1);
    @(negedge clk); #2 check("wflush_req", req, 1'b1);
    @(negedge clk); flush_m = 1'b1;
    #2 check("wflush_stall_w1", stall_o, 1'b1);
    @(negedge clk); flush_m = 1'b0; memen_m = 1'b0;
    #2 check("wflush_stall_w2", stall_o, 1'b1);
    @(negedge clk); #2 check("wflush_stall_w3", stall_o, 1'b1);
    @(negedge clk); #2;
    check("wflush_stall_after", stall_o, 1'b0);
    check("wflush_req_after", req, 1'b0);
    check("wflush_rdata_o", rdata_o, 32'hDEAD_BEEF);

    // half load held in DONE for 2 cycles, then back-to-back reserved-size load
    access("ld_half_hold", 1'b0, SZ_HALF, SZ_HALF, 32'h0000_4002, 32'h0, 1, 1, 32'hA5A5_0000, 2);
    check("ld_half_rdata_o", rdata_o, 32'hA5A5_0000);
    access("ld_rsvd", 1'b0, 2'd3, SZ_WORD, 32'h0000_5000, 32'h0, 0, 0, 32'h0BAD_F00D, 0);
    check("ld_rsvd_rdata_o", rdata_o, 32'h0BAD_F00D);

    // stray handshakes while idle are ignored
    @(negedge clk);
    memen_m = 1'b0;
    #2 stray = 1'b1;
    @(negedge clk);
    #2 stray = 1'b0;
    @(negedge clk); #2;
    check("stray_stall", stall_o, 1'b0);
    check("stray_req", req, 1'b0);
    check("stray_rdata_o", rdata_o, 32'h0BAD_F00D);

    // asynchronous reset while in WAIT
    ao_delay = 0; do_delay = 5; bus_rdata = 32'hFFFF_FFFF;
    exp_req_q.push_back(mk_req(1'b0, SZ_WORD, 32'h0000_8000, 32'h0));
    @(negedge clk);
    memen_m = 1'b1; memwrite_m = 1'b0; size_m = SZ_WORD; addr_m = 32'h0000_8000; wdata_m = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_req", req, 1'b0);
    check("arst_rdata_o", rdata_o, 32'h0);
    check("arst_addr", addr, 32'h0);
    check("arst_stall_comb", stall_o, 1'b1);
    memen_m = 1'b0;
    #1 check("arst_idle_stall", stall_o, 1'b0);
    model_rdata = 32'h0;
    @(negedge clk); #2 rst = 1'b1;
    access("ld_after_rst", 1'b0, SZ_WORD, SZ_WORD, 32'h0000_9000, 32'h0, 0, 0, 32'hCAFE_F00D, 0);
    check("ld_after_rst_rdata_o", rdata_o, 32'hCAFE_F00D);

    @(negedge clk);
    memen_m = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("req_queue_drained", exp_req_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_req_bridge.md
# mem_req_bridge

Memory-stage request bridge between the pipeline's memory-stage control (memen/memwrite from the controller) and the data-side SRAM-like handshake bus. It turns one pipeline memory access into exactly one bus transaction (req/addr_ok/data_ok), holds the pipeline with a stall while the transaction is outstanding, and returns load data. It also absorbs a memory-stage flush once a transaction has left the core.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- memen_m  in  1  memory-stage instruction accesses memory
- memwrite_m  in  1  1 = store, 0 = load; valid with memen_m
- size_m  in  2  0 = byte, 1 = half, 2 = word (3 reserved, treated as word)
- addr_m  in  ADDR_W  byte address
- wdata_m  in  DATA_W  store data, already lane-aligned
- flush_m  in  1  memory-stage flush (exception/eret)
- hold_m  in  1  memory stage held by a stall source other than this block
- stall_o  out  1  hold the pipeline
- rdata_o  out  DATA_W  load data, valid while state is DONE
- req  out  1  bus request
- wr  out  1  bus write
- size  out  2  bus size
- addr  out  ADDR_W  bus address
- wdata  out  DATA_W  bus write data
- addr_ok  in  1  request accepted, sampled only while req = 1
- data_ok  in  1  response (load data or store completion)
- rdata  in  DATA_W  bus read data, valid with data_ok

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE → REQ when memen_m & ~flush_m. On that edge, latch wr, size, addr and wdata from the _m inputs and clear the cancel flag.
- REQ: req = 1. When addr_ok = 1, go to WAIT. req and the latched fields must hold stable until addr_ok.
- WAIT: when data_ok = 1:
  - cancel = 0: go to DONE; for a load, latch rdata into rdata_o.
  - cancel = 1: go to IDLE; rdata_o is not updated.
- DONE: stall_o = 0. Go to IDLE unless hold_m = 1; while held, stay in DONE.
  - No new request is issued from DONE, even though memen_m is still high for the same instruction.
- Cancel flag: set when flush_m = 1 in REQ or WAIT. A transaction already issued always completes on the bus; it is never abandoned.
- stall_o is (IDLE & memen_m & ~flush_m) | REQ | WAIT.
- In IDLE, flush_m = 1 suppresses the request entirely: no stall, no transaction.
- data_ok outside WAIT and addr_ok outside REQ are ignored.
- Reset values: state IDLE; req 0, wr 0, size 0, addr 0, wdata 0, rdata_o 0, cancel 0.
  - stall_o follows its combinational equation, so it equals memen_m & ~flush_m during reset.
- rst asserted mid-transaction returns the block to IDLE immediately. The bus is expected to be reset together with the core.

## Timing
- Best-case load or store: cycle 0 IDLE (stall, latch), cycle 1 REQ with addr_ok, cycle 2 WAIT with data_ok, cycle 3 DONE (stall low). The pipeline advances at the end of cycle 3.
- Each cycle without addr_ok adds one cycle in REQ. Each cycle without data_ok adds one cycle in WAIT.
- The bus guarantees data_ok no earlier than the cycle after addr_ok.
- Back-to-back accesses: the next instruction's request starts in the cycle after DONE, giving a minimum spacing of 4 cycles.
- rdata_o changes only on the WAIT→DONE edge and holds until the next such edge.

## Structure
- Shared package (with the controller's decode constants):
  - state enum {IDLE, REQ, WAIT, DONE}
  - size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2
- Single module. The payload latch and state register stay inline; no sub-module is needed.
- Target size: about 150 lines.

## Test plan
- Word load at 0x0000_1000: addr_ok in the first REQ cycle, data_ok next cycle with rdata = 0xDEAD_BEEF → stall_o high for exactly 3 cycles, rdata_o = 0xDEAD_BEEF in DONE, one req pulse.
- Byte store (addr 0x0000_2003, wdata 0x1100_0000), addr_ok delayed 3 cycles → req, addr, size = 0 and wr = 1 held stable across all 4 REQ cycles, stall held, exactly one transaction.
- flush_m in IDLE with memen_m = 1 → no req, stall_o = 0.
- flush_m during WAIT, then data_ok with rdata = 0x1234_5678 → FSM returns to IDLE, rdata_o keeps its old value, stall_o high until data_ok.
- hold_m = 1 for 2 cycles while in DONE with memen_m still 1 → FSM stays in DONE, no second req, stall_o = 0.
- rst pulsed low while in WAIT → req = 0, state IDLE and rdata_o = 0 immediately (asynchronous); a later load completes normally.
